// File: rtl/fetch_queue.sv
// Fetch buffer between the PC/ROM fetch stage and decode: small FIFO of {pc, instr} pairs.
// Optional same-cycle empty-queue bypass from if_* to id_* is enabled by FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       if_valid,
    input  logic [XLEN-1:0]            if_pc,
    input  logic [XLEN-1:0]            if_instr,
    output logic                       fetch_stall,
    input  logic                       flush,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_instr,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h0000_0013);
    localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [LW-1:0] level_reg, level_next;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic bypass_take;

    assign full  = (level_reg == FULL_LEVEL);
    assign empty = (level_reg == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // A word that decode takes straight off the fetch bus never occupies an entry.
    assign bypass_take = empty & if_valid & ~flush & id_ready;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = if_valid & ~full & ~flush & ~bypass_take;
    assign pop  = ~empty & id_ready & ~flush;

    // The PC unit holds whenever the word on the bus cannot be accepted.
    assign fetch_stall = full;
    assign level       = level_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        level_next  = level_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_next = level_reg + LW'(1);
                2'b01:   level_next = level_reg - LW'(1);
                default: level_next = level_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Storage has no reset; level alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= if_pc;
            instr_mem[wr_ptr_reg] <= if_instr;
        end
    end

    always_comb begin
        id_valid = ~empty;
        id_pc    = '0;
        id_instr = NOP_INSTR;
        if (!empty) begin
            id_pc    = pc_mem[rd_ptr_reg];
            id_instr = instr_mem[rd_ptr_reg];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (empty && if_valid && !flush) begin
            id_valid = 1'b1;
            id_pc    = if_pc;
            id_instr = if_instr;
        end
`endif
    end

endmodule
